// File: rtl/eth_link_manager.sv
// Bring-up and recovery sequencer for a 10G Ethernet GTX transceiver path.
// Sequences soft/RX resets, waits for reset-done and block lock, retries on timeout.
module eth_link_manager #(
    parameter int RST_PULSE_CYCLES = 64,
    parameter int DONE_TIMEOUT     = 1048576,
    parameter int LOCK_TIMEOUT     = 262144,
    parameter int LOCK_STABLE      = 1024,
    parameter int MAX_RETRIES      = 7
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_reset_n,
    input  logic        i_enable,
    input  logic        i_tx_reset_done,
    input  logic        i_rx_reset_done,
    input  logic        i_rx_block_lock,
    input  logic [2:0]  i_loopback_req,
    input  logic        i_loopback_update,
    output logic        o_gtx_soft_reset,
    output logic        o_gtx_rx_reset,
    output logic [2:0]  o_gtx_loopback,
    output logic        o_link_up,
    output logic        o_fail,
    output logic [2:0]  o_state,
    output logic [3:0]  o_retry_cnt,
    output logic [15:0] o_link_drop_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TX_RST    = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RX_RST    = 3'd4,
        ST_WAIT_RX   = 3'd5,
        ST_LINK_UP   = 3'd6,
        ST_FAIL      = 3'd7
    } state_e;

    localparam int CNT_MAX_A = (DONE_TIMEOUT > LOCK_TIMEOUT) ? DONE_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > RST_PULSE_CYCLES) ? CNT_MAX_A : RST_PULSE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam int STB_W     = $clog2(LOCK_STABLE + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STABLE_N   = STB_W'(LOCK_STABLE);
    localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STB_W-1:0]  stable_q, stable_d;
    logic [3:0]        retry_q, retry_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              fail_q, fail_d;
    logic [2:0]        loopback_q, loopback_d;
    logic              soft_reset_q, soft_reset_d;
    logic              rx_reset_q, rx_reset_d;
    logic              link_up_q, link_up_d;
    logic [2:0]        sync_meta_q, sync_meta_d;
    logic [2:0]        sync_q, sync_d;

    logic              tx_s, rx_s, lock_s;
    logic              timeout;
    state_e            timeout_target;
    logic              drop;

    assign tx_s   = sync_q[2];
    assign rx_s   = sync_q[1];
    assign lock_s = sync_q[0];

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        sync_meta_d    = {i_tx_reset_done, i_rx_reset_done, i_rx_block_lock};
        sync_d         = sync_meta_q;
        state_d        = state_q;
        cnt_d          = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        stable_d       = stable_q;
        retry_d        = retry_q;
        drop_cnt_d     = drop_cnt_q;
        fail_d         = fail_q;
        loopback_d     = i_loopback_update ? i_loopback_req : loopback_q;
        timeout        = 1'b0;
        timeout_target = ST_TX_RST;
        drop           = 1'b0;

        if (!i_enable) begin
            state_d = ST_IDLE;
        end else if (i_loopback_update &&
                     (state_q inside {ST_WAIT_LOCK, ST_WAIT_RX, ST_LINK_UP})) begin
            // A new loopback mode needs a fresh RX path; this is neither a retry nor a drop.
            state_d = ST_RX_RST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TX_RST;
                    retry_d = '0;
                    fail_d  = 1'b0;
                end
                ST_TX_RST: begin
                    if (cnt_q == PULSE_LAST) state_d = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_s && rx_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == DONE_LAST) begin
                        timeout        = 1'b1;
                        timeout_target = ST_TX_RST;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!rx_s) begin
                        state_d = ST_RX_RST;
                    end else if (lock_s && stable_q == STABLE_N) begin
                        state_d = ST_LINK_UP;
                    end else if (cnt_q == LOCK_LAST) begin
                        timeout        = 1'b1;
                        timeout_target = ST_RX_RST;
                    end else begin
                        stable_d = lock_s ? stable_q + 1'b1 : '0;
                    end
                end
                ST_RX_RST: begin
                    if (cnt_q == PULSE_LAST) state_d = ST_WAIT_RX;
                end
                ST_WAIT_RX: begin
                    if (rx_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == DONE_LAST) begin
                        timeout        = 1'b1;
                        timeout_target = ST_TX_RST;
                    end
                end
                ST_LINK_UP: begin
                    // A TX loss needs the full reset, so it wins over an RX-side loss.
                    if (!tx_s) begin
                        state_d = ST_TX_RST;
                        drop    = 1'b1;
                    end else if (!lock_s || !rx_s) begin
                        state_d = ST_RX_RST;
                        drop    = 1'b1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (timeout) begin
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
            end else begin
                state_d = timeout_target;
                retry_d = retry_q + 1'b1;
            end
        end

        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;

        if (state_d != state_q) begin
            cnt_d    = '0;
            stable_d = '0;
            if (state_d == ST_LINK_UP) retry_d = '0;
        end

        soft_reset_d = (state_d inside {ST_IDLE, ST_TX_RST, ST_FAIL});
        rx_reset_d   = (state_d == ST_RX_RST);
        link_up_d    = (state_d == ST_LINK_UP);
    end

    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stable_q     <= '0;
            retry_q      <= '0;
            drop_cnt_q   <= '0;
            fail_q       <= 1'b0;
            loopback_q   <= '0;
            soft_reset_q <= 1'b1;
            rx_reset_q   <= 1'b0;
            link_up_q    <= 1'b0;
            sync_meta_q  <= '0;
            sync_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            retry_q      <= retry_d;
            drop_cnt_q   <= drop_cnt_d;
            fail_q       <= fail_d;
            loopback_q   <= loopback_d;
            soft_reset_q <= soft_reset_d;
            rx_reset_q   <= rx_reset_d;
            link_up_q    <= link_up_d;
            sync_meta_q  <= sync_meta_d;
            sync_q       <= sync_d;
        end
    end

    assign o_gtx_soft_reset = soft_reset_q;
    assign o_gtx_rx_reset   = rx_reset_q;
    assign o_gtx_loopback   = loopback_q;
    assign o_link_up        = link_up_q;
    assign o_fail           = fail_q;
    assign o_state          = state_q;
    assign o_retry_cnt      = retry_q;
    assign o_link_drop_cnt  = drop_cnt_q;

endmodule

// File: doc/eth_link_manager.md
Name: eth_link_manager

Overview:
- Bring-up and recovery sequencer for the 10G Ethernet transceiver path, running on the free-running system clock.
- Drives the GTX wizard soft reset, RX-only reset and loopback select.
- Watches TX/RX reset-done and the RX PCS block lock, and retries with timeouts.
- Reports link status and drop/retry counters to the management logic.

Parameters:
- RST_PULSE_CYCLES, 64: width of every reset pulse it issues, in i_sys_clk cycles (>=2).
- DONE_TIMEOUT, 1048576: cycles allowed for reset-done after a reset pulse.
- LOCK_TIMEOUT, 262144: cycles allowed to reach stable block lock.
- LOCK_STABLE, 1024: consecutive cycles of block lock required before declaring link up.
- MAX_RETRIES, 7: timeouts tolerated before FAIL (1..15).

Ports:
- i_sys_clk  in  1  system clock; the only clock.
- i_sys_reset_n  in  1  synchronous, active-low reset.
- i_enable  in  1  1 = bring the link up; 0 = hold the transceiver in reset.
- i_tx_reset_done  in  1  GTX TX FSM reset done; asynchronous.
- i_rx_reset_done  in  1  GTX RX FSM reset done; asynchronous.
- i_rx_block_lock  in  1  PCS RX block lock (rx_clk domain); asynchronous.
- i_loopback_req  in  3  requested GTX loopback mode.
- i_loopback_update  in  1  one-cycle strobe that applies i_loopback_req.
- o_gtx_soft_reset  out  1  to GTX soft_reset_tx_in/soft_reset_rx_in.
- o_gtx_rx_reset  out  1  to GTX gtrxreset.
- o_gtx_loopback  out  3  to GTX loopback_in.
- o_link_up  out  1  link usable.
- o_fail  out  1  retries exhausted; sticky until i_enable=0.
- o_state  out  3  current state encoding.
- o_retry_cnt  out  4  timeouts since last LINK_UP.
- o_link_drop_cnt  out  16  LINK_UP exits from lock loss; saturating.

Behaviour:
- Reset (i_sys_reset_n=0 at an edge):
  - state=IDLE, o_gtx_soft_reset=1, o_gtx_rx_reset=0, o_gtx_loopback=0.
  - o_link_up=0, o_fail=0, both counters 0.
- Input synchronisation and timing:
  - The three status inputs pass through a 2-flop synchroniser in-block.
  - All outputs are registered.
  - Latency from an input edge to a state or output change is 3 cycles.
- State encodings: IDLE=0, TX_RST=1, WAIT_DONE=2, WAIT_LOCK=3, RX_RST=4, WAIT_RX=5, LINK_UP=6, FAIL=7.
- Cycle counter: one shared counter, cleared on every state entry.
- IDLE:
  - o_gtx_soft_reset=1.
  - i_enable=1 -> TX_RST; o_retry_cnt and o_fail are cleared on that transition.
- TX_RST:
  - o_gtx_soft_reset=1 for exactly RST_PULSE_CYCLES cycles, then -> WAIT_DONE.
- WAIT_DONE:
  - Synced tx_done AND rx_done both 1 -> WAIT_LOCK.
  - DONE_TIMEOUT cycles elapsed -> timeout event, re-enter TX_RST.
- WAIT_LOCK:
  - LOCK_STABLE consecutive synced lock cycles -> LINK_UP; any lock deassertion restarts the stability count.
  - LOCK_TIMEOUT elapsed -> timeout event, go to RX_RST.
  - Loss of rx_done -> RX_RST (not a timeout).
- RX_RST:
  - o_gtx_rx_reset=1 for RST_PULSE_CYCLES cycles, then -> WAIT_RX.
- WAIT_RX:
  - Synced rx_done=1 -> WAIT_LOCK.
  - DONE_TIMEOUT elapsed -> timeout event, go to TX_RST.
- Timeout event:
  - o_retry_cnt increments.
  - If o_retry_cnt was already MAX_RETRIES, go to FAIL instead.
- LINK_UP:
  - On entry: o_link_up=1 and o_retry_cnt cleared.
  - Synced lock=0 or rx_done=0 -> o_link_drop_cnt increments (saturates at 0xFFFF) and state -> RX_RST.
  - Synced tx_done=0 -> TX_RST; counts as a drop.
  - tx_done=0 takes precedence when both TX and RX losses occur.
- FAIL:
  - o_fail=1 and o_gtx_soft_reset=1.
  - Stays in FAIL until i_enable=0, then -> IDLE.
- i_enable=0 in any state -> IDLE on the next edge; o_link_up=0 and o_gtx_rx_reset=0 in the same cycle. This has priority over everything except reset.
- Loopback update (i_loopback_update=1):
  - o_gtx_loopback <= i_loopback_req on the next edge, in every state.
  - In WAIT_LOCK, WAIT_RX or LINK_UP, the state also goes to RX_RST. This counts as neither a retry nor a drop.
  - If it coincides with a timeout or a drop in the same cycle, only the loopback path is taken and no counter changes.
  - A strobe during TX_RST or RX_RST updates the register only; the pulse is not restarted.

Test Plan:
1. Nominal bring-up. Overrides RST_PULSE=4, LOCK_STABLE=8. Enable; raise tx/rx_done 10 cycles later and lock 5 cycles after that.
   -> soft_reset high for exactly 4 cycles after leaving IDLE.
   -> o_link_up=1 exactly 3+8 cycles after lock rises.
   -> o_state=6, retry_cnt=0.
2. Reset-done timeout. DONE_TIMEOUT=20, MAX_RETRIES=2, done never rises.
   -> three soft_reset pulses, retry_cnt 0->1->2.
   -> o_fail=1 and state=7 on the third timeout.
   -> drop i_enable -> IDLE, soft_reset=1; re-enable -> fail and retry_cnt cleared.
3. Link drop in LINK_UP. Deassert lock for 1 cycle.
   -> link_up falls 3 cycles later, drop_cnt=1, one rx_reset pulse of RST_PULSE cycles.
   -> link returns with no soft_reset pulse.
4. Lock chatter. Lock toggles every 5 cycles with LOCK_STABLE=8.
   -> no LINK_UP.
   -> LOCK_TIMEOUT fires -> RX_RST with retry_cnt=1.
5. Loopback change while up. Strobe update with req=3'b010.
   -> o_gtx_loopback=2 next cycle, RX_RST, drop_cnt and retry_cnt unchanged.
   -> same strobe in IDLE -> register only, state stays 0.
6. Counter saturation. Preload drop_cnt to 0xFFFE, then force 3 drops.
   -> count ends at 0xFFFF.
   -> mid-sequence i_sys_reset_n=0 -> all reset values on the next edge.
